// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: register-access front-end for the SPI master.
// Queues host requests and packs each into a 32-bit MSB-first word at enqueue.
// Issues one SPI transaction at a time and returns one response per request.
// Optional statistics counters are built when SPI_SEQ_STATS_EN is defined.
module spi_cmd_seq #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cfg_adr_bits,
  input  logic [7:0]  cfg_dat_bits,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_rw,
  output logic        rsp_err,
  output logic [23:0] rsp_rdata,
  output logic        spi_tx_tvalid,
  output logic [31:0] spi_tx_tdata,
  input  logic        spi_tx_tready,
  input  logic        spi_rx_tvalid,
  input  logic [31:0] spi_rx_tdata,
  output logic        busy,
  output logic [15:0] stat_txn_cnt,
  output logic [15:0] stat_tmo_cnt
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] TmoLast  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  // Request packing, using the configuration sampled in the enqueue cycle
  logic [8:0]  sum_bits;
  logic        cfg_bad;
  logic [7:0]  adr_shift, dat_shift;
  logic [31:0] addr_mask, data_mask, pack_word;

  assign sum_bits = {1'b0, cfg_adr_bits} + {1'b0, cfg_dat_bits};
  assign cfg_bad  = (cfg_adr_bits < 8'd2) || (cfg_dat_bits == 8'd0) || (sum_bits > 9'd32);

  // Build the packed word; bad configurations carry an all-zero word
  always_comb begin
    adr_shift = 8'd32 - cfg_adr_bits;
    dat_shift = adr_shift - cfg_dat_bits;
    addr_mask = (32'h1 << (cfg_adr_bits - 8'd1)) - 32'h1;
    data_mask = (32'h1 << cfg_dat_bits) - 32'h1;
    pack_word = 32'h0;
    if (!cfg_bad) begin
      pack_word = {req_rw, 31'h0} | (({8'h0, req_addr} & addr_mask) << adr_shift);
      if (!req_rw) pack_word = pack_word | (({8'h0, req_wdata} & data_mask) << dat_shift);
    end
  end

  // Command FIFO
  logic [31:0]     fifo_word  [FIFO_DEPTH];
  logic            fifo_rw    [FIFO_DEPTH];
  logic [7:0]      fifo_dbits [FIFO_DEPTH];
  logic            fifo_bad   [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            fifo_empty, fifo_full, push, pop, ready_en_q;
  logic [2:0]      state_q, state_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntFull);
  assign req_ready  = ready_en_q & ~fifo_full;
  assign push       = req_valid & req_ready;
  assign pop        = (state_q == ST_IDLE) & ~fifo_empty;

  // Entry storage, no reset needed since occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word[wr_ptr_q]  <= pack_word;
      fifo_rw[wr_ptr_q]    <= req_rw;
      fifo_dbits[wr_ptr_q] <= cfg_dat_bits;
      fifo_bad[wr_ptr_q]   <= cfg_bad;
    end
  end

  // Pointer/occupancy tracking; ready is held low until the first cycle after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Transaction FSM
  logic [31:0] tx_word_q, tx_word_d, timer_q, timer_d;
  logic        rw_q, rw_d, err_q, err_d, tmo_evt;
  logic [7:0]  dbits_q, dbits_d;
  logic [23:0] rdata_q, rdata_d, dmask;
  logic        unused_rx;

  assign unused_rx = ^spi_rx_tdata[31:24];
  assign dmask = (dbits_q >= 8'd24) ? 24'hFFFFFF : ((24'h1 << dbits_q) - 24'h1);

  // Next-state logic; the timer guards both wait states
  always_comb begin
    state_d   = state_q;
    tx_word_d = tx_word_q;
    rw_d      = rw_q;
    dbits_d   = dbits_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    timer_d   = timer_q;
    tmo_evt   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          tx_word_d = fifo_word[rd_ptr_q];
          rw_d      = fifo_rw[rd_ptr_q];
          dbits_d   = fifo_dbits[rd_ptr_q];
          err_d     = fifo_bad[rd_ptr_q];
          rdata_d   = 24'h0;
          state_d   = fifo_bad[rd_ptr_q] ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (spi_tx_tready) begin
          timer_d = 32'h0;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (timer_q >= TmoLast) begin
          tmo_evt = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 32'h1;
          if (!spi_tx_tready) state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (rw_q && spi_rx_tvalid) begin
          rdata_d = spi_rx_tdata[23:0] & dmask;
          state_d = ST_RESP;
        end else if (!rw_q && spi_tx_tready) begin
          state_d = ST_RESP;
        end else if (timer_q >= TmoLast) begin
          tmo_evt = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 32'h1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_word_q <= 32'h0;
      rw_q      <= 1'b0;
      dbits_q   <= 8'h0;
      err_q     <= 1'b0;
      rdata_q   <= 24'h0;
      timer_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      tx_word_q <= tx_word_d;
      rw_q      <= rw_d;
      dbits_q   <= dbits_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
    end
  end

  assign spi_tx_tvalid = (state_q == ST_ISSUE);
  assign spi_tx_tdata  = tx_word_q;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_rw        = rw_q;
  assign rsp_err       = err_q;
  assign rsp_rdata     = rdata_q;
  assign busy          = ~fifo_empty | (state_q != ST_IDLE);

`ifdef SPI_SEQ_STATS_EN
  logic [15:0] txn_cnt_q, tmo_cnt_q;

  // Saturating response and timeout counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_q <= 16'h0;
      tmo_cnt_q <= 16'h0;
    end else begin
      if (rsp_valid && rsp_ready && txn_cnt_q != 16'hFFFF) txn_cnt_q <= txn_cnt_q + 16'h1;
      if (tmo_evt && tmo_cnt_q != 16'hFFFF)                 tmo_cnt_q <= tmo_cnt_q + 16'h1;
    end
  end

  assign stat_txn_cnt = txn_cnt_q;
  assign stat_tmo_cnt = tmo_cnt_q;
`else
  logic unused_tmo;
  assign unused_tmo   = tmo_evt;
  assign stat_txn_cnt = 16'h0;
  assign stat_tmo_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Self-checking bench for spi_cmd_seq with a behavioural SPI master model.
module tb_spi_cmd_seq;

  localparam int unsigned FD  = 8;
  localparam int unsigned TMO = 100;

  logic        clk, rst_n;
  logic [7:0]  cfg_adr_bits, cfg_dat_bits;
  logic        req_valid, req_ready, req_rw;
  logic [23:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_rw, rsp_err;
  logic [23:0] rsp_rdata;
  logic        spi_tx_tvalid, spi_tx_tready, spi_rx_tvalid;
  logic [31:0] spi_tx_tdata, spi_rx_tdata;
  logic        busy;
  logic [15:0] stat_txn_cnt, stat_tmo_cnt;

  int checks = 0;
  int errors = 0;
  int rsp_count = 0;
  int tmo_count = 0;

  spi_cmd_seq #(.FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_adr_bits(cfg_adr_bits), .cfg_dat_bits(cfg_dat_bits),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .spi_tx_tvalid(spi_tx_tvalid), .spi_tx_tdata(spi_tx_tdata),
    .spi_tx_tready(spi_tx_tready), .spi_rx_tvalid(spi_rx_tvalid),
    .spi_rx_tdata(spi_rx_tdata), .busy(busy),
    .stat_txn_cnt(stat_txn_cnt), .stat_tmo_cnt(stat_tmo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: field layout computed with plain arithmetic
  function automatic bit model_legal(int a, int d);
    return (a >= 2) && (d >= 1) && (a + d <= 32);
  endfunction

  function automatic logic [31:0] model_word(logic rw, int a, int d, logic [23:0] addr,
                                             logic [23:0] wdata);
    longint w;
    w = rw ? (longint'(1) << 31) : 0;
    w = w + (longint'(addr) % (longint'(1) << (a - 1))) * (longint'(1) << (32 - a));
    if (!rw) w = w + (longint'(wdata) % (longint'(1) << d)) * (longint'(1) << (32 - a - d));
    return w[31:0];
  endfunction

  function automatic logic [23:0] model_rdata(logic [31:0] rx, int d);
    longint v;
    v = longint'(rx) % (longint'(1) << d);
    v = v % (longint'(1) << 24);
    return v[23:0];
  endfunction

  task automatic push_req(input logic rw, input int a, input int d, input logic [23:0] addr,
                          input logic [23:0] wdata);
    int n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: req_ready=%b required 1", req_ready);
    end
    cfg_adr_bits = 8'(a); cfg_dat_bits = 8'(d);
    req_rw = rw; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    // Scramble config to show it is sampled only at enqueue
    cfg_adr_bits = 8'($urandom); cfg_dat_bits = 8'($urandom);
  endtask

  // Plays the master for the FSM's current head transaction and checks the response
  task automatic serve_one(input logic rw, input int a, input int d, input logic [23:0] addr,
                           input logic [23:0] wdata, input logic [31:0] rx, input int pre,
                           input int bcyc, input string name);
    logic [31:0] exp_w;
    logic        exp_err;
    logic [23:0] exp_rd;
    int n;
    bit saw_tv = 0;
    exp_err = !model_legal(a, d);
    exp_w   = exp_err ? 32'h0 : model_word(rw, a, d, addr, wdata);
    exp_rd  = (rw && !exp_err) ? model_rdata(rx, d) : 24'h0;
    spi_tx_tready = 1'b0;
    if (!exp_err) begin
      n = 0;
      while (!spi_tx_tvalid && n < 50) begin tick(); n++; end
      checks++;
      if (spi_tx_tvalid !== 1'b1 || spi_tx_tdata !== exp_w) begin
        errors++;
        $display("FAIL %s tdata: tvalid=%b tdata=%h required 1/%h", name, spi_tx_tvalid,
                 spi_tx_tdata, exp_w);
      end
      for (int i = 0; i < pre; i++) begin
        tick();
        checks++;
        if (spi_tx_tvalid !== 1'b1 || spi_tx_tdata !== exp_w) begin
          errors++;
          $display("FAIL %s tx_hold: tvalid=%b tdata=%h required 1/%h", name, spi_tx_tvalid,
                   spi_tx_tdata, exp_w);
        end
      end
      spi_tx_tready = 1'b1;
      tick();
      checks++;
      if (spi_tx_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL %s tvalid_drop: tvalid=%b required 0", name, spi_tx_tvalid);
      end
      spi_tx_tready = 1'b0;
      repeat (bcyc) tick();
      if (rw) begin spi_rx_tvalid = 1'b1; spi_rx_tdata = rx; end
      spi_tx_tready = 1'b1;
      tick();
      spi_rx_tvalid = 1'b0;
      spi_rx_tdata = $urandom;
    end
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (spi_tx_tvalid) saw_tv = 1;
      tick();
      n++;
    end
    if (exp_err) begin
      checks++;
      if (saw_tv || spi_tx_tvalid) begin
        errors++;
        $display("FAIL %s bad_no_tx: saw tvalid=1 required none", name);
      end
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rw !== rw || rsp_err !== exp_err || rsp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL %s rsp: valid=%b rw=%b err=%b rdata=%h required 1/%b/%b/%h", name,
               rsp_valid, rsp_rw, rsp_err, rsp_rdata, rw, exp_err, exp_rd);
    end
    rsp_ready = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rw !== rw || rsp_err !== exp_err || rsp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL %s rsp_hold: valid=%b rw=%b err=%b rdata=%h required 1/%b/%b/%h", name,
               rsp_valid, rsp_rw, rsp_err, rsp_rdata, rw, exp_err, exp_rd);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    rsp_count++;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s rsp_drop: rsp_valid=%b required 0", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_rw, rsp_err, rsp_rdata, spi_tx_tvalid, spi_tx_tdata, busy,
         stat_txn_cnt, stat_tmo_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rv=%b tv=%b tdata=%h busy=%b required all 0",
               req_ready, rsp_valid, spi_tx_tvalid, spi_tx_tdata, busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_write();
    spi_tx_tready = 1'b0;
    push_req(1'b0, 16, 8, 24'h000012, 24'h0000AB);
    checks++;
    if (spi_tx_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_lat1: tvalid=%b required 0", spi_tx_tvalid);
    end
    tick();
    checks++;
    if (spi_tx_tvalid !== 1'b1 || spi_tx_tdata !== 32'h0012AB00) begin
      errors++;
      $display("FAIL write_lat2: tvalid=%b tdata=%h required 1/0012ab00", spi_tx_tvalid,
               spi_tx_tdata);
    end
    serve_one(1'b0, 16, 8, 24'h12, 24'hAB, 32'h0, 3, 40, "write");
  endtask

  task automatic test_read();
    push_req(1'b1, 8, 24, 24'h000005, 24'h0);
    checks++;
    if (model_word(1'b1, 8, 24, 24'h5, 24'h0) !== 32'h85000000) begin
      errors++;
      $display("FAIL read_model: word=%h required 85000000", model_word(1'b1, 8, 24, 24'h5, 0));
    end
    serve_one(1'b1, 8, 24, 24'h5, 24'h0, 32'h00C0FFEE, 2, 10, "read");
  endtask

  task automatic test_illegal();
    int as [5] = '{24, 1, 8, 0, 31};
    int ds [5] = '{16, 8, 0, 0, 2};
    for (int i = 0; i < 5; i++) begin
      logic rw = 1'($urandom);
      logic [23:0] ad = 24'($urandom), wd = 24'($urandom);
      push_req(rw, as[i], ds[i], ad, wd);
      serve_one(rw, as[i], ds[i], ad, wd, 32'h0, 0, 0, "illegal");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int a = $urandom_range(2, 31);
      int d = $urandom_range(1, 32 - a);
      logic rw = 1'($urandom);
      logic [23:0] ad = 24'($urandom), wd = 24'($urandom);
      logic [31:0] rx = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        a = $urandom_range(20, 31);
        d = $urandom_range(33 - a, 32);
      end
      push_req(rw, a, d, ad, wd);
      serve_one(rw, a, d, ad, wd, rx, $urandom_range(0, 3), $urandom_range(1, 30), "random");
    end
  endtask

  task automatic test_fifo_full();
    logic        rws [FD + 4];
    int          as_ [FD + 4];
    int          ds_ [FD + 4];
    logic [23:0] ads [FD + 4];
    logic [23:0] wds [FD + 4];
    int accepted = 0;
    spi_tx_tready = 1'b0;
    rsp_ready = 1'b0;
    for (int k = 0; k < FD + 4; k++) begin
      if (!req_ready) break;
      rws[k] = 1'($urandom);
      as_[k] = $urandom_range(2, 20);
      ds_[k] = $urandom_range(1, 32 - as_[k]);
      ads[k] = 24'(k * 24'h111 + 24'h7);
      wds[k] = 24'($urandom);
      cfg_adr_bits = 8'(as_[k]); cfg_dat_bits = 8'(ds_[k]);
      req_rw = rws[k]; req_addr = ads[k]; req_wdata = wds[k]; req_valid = 1'b1;
      tick();
      accepted++;
    end
    req_valid = 1'b0;
    checks++;
    if (accepted != FD + 1) begin
      errors++;
      $display("FAIL fifo_accepts: accepted=%0d required %0d", accepted, FD + 1);
    end
    repeat (3) tick();
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full_hold: req_ready=%b busy=%b required 0/1", req_ready, busy);
    end
    for (int k = 0; k < accepted && k < FD + 4; k++)
      serve_one(rws[k], as_[k], ds_[k], ads[k], wds[k], $urandom, 1, $urandom_range(1, 8),
                "fifo_order");
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_drain: busy=%b req_ready=%b required 0/1", busy, req_ready);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int limit = 0;
    spi_tx_tready = 1'b0;
    push_req(1'b1, 8, 24, 24'h33, 24'h0);
    while (!spi_tx_tvalid && limit < 50) begin tick(); limit++; end
    spi_tx_tready = 1'b1;
    tick();
    while (!rsp_valid && n < TMO + 20) begin
      spi_rx_tvalid = (n == 5);
      spi_rx_tdata = 32'h00ABCDEF;
      tick();
      n++;
    end
    spi_rx_tvalid = 1'b0;
    checks++;
    if (n != TMO || rsp_err !== 1'b1 || rsp_rdata !== 24'h0 || rsp_rw !== 1'b1) begin
      errors++;
      $display("FAIL timeout: cycles=%0d err=%b rdata=%h rw=%b required %0d/1/000000/1", n,
               rsp_err, rsp_rdata, rsp_rw, TMO);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    rsp_count++;
    tmo_count++;
`ifdef SPI_SEQ_STATS_EN
    checks++;
    if (stat_tmo_cnt !== 16'(tmo_count) || stat_txn_cnt !== 16'(rsp_count)) begin
      errors++;
      $display("FAIL stats: tmo=%0d txn=%0d required %0d/%0d", stat_tmo_cnt, stat_txn_cnt,
               tmo_count, rsp_count);
    end
`else
    checks++;
    if (stat_tmo_cnt !== 16'h0 || stat_txn_cnt !== 16'h0) begin
      errors++;
      $display("FAIL stats_off: tmo=%0d txn=%0d required 0/0", stat_tmo_cnt, stat_txn_cnt);
    end
`endif
    // Recovery: next transaction runs normally after a timeout
    push_req(1'b0, 12, 12, 24'h0ABC, 24'h0DEF);
    serve_one(1'b0, 12, 12, 24'h0ABC, 24'h0DEF, 32'h0, 1, 5, "post_timeout");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int limit = 0;
    spi_tx_tready = 1'b0;
    rsp_ready = 1'b0;
    push_req(1'b0, 16, 8, 24'h44, 24'h55);
    while (!spi_tx_tvalid && limit < 50) begin tick(); limit++; end
    spi_tx_tready = 1'b1;
    tick();
    spi_tx_tready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) push_req(1'b1, 16, 8, 24'(k + 1), 24'h0);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: busy=%b req_ready=%b required 1/1", busy, req_ready);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({req_ready, rsp_valid, rsp_rw, rsp_err, rsp_rdata, spi_tx_tvalid, spi_tx_tdata, busy,
         stat_txn_cnt, stat_tmo_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ready=%b rv=%b tv=%b tdata=%h busy=%b required all 0",
               req_ready, rsp_valid, spi_tx_tvalid, spi_tx_tdata, busy);
    end
    rsp_count = 0;
    tmo_count = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    spi_tx_tready = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid || spi_tx_tvalid || busy) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: active_cycles=%0d busy=%b req_ready=%b required 0/0/1",
               seen, busy, req_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_adr_bits = 8'd16; cfg_dat_bits = 8'd8;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = 24'h0; req_wdata = 24'h0;
    rsp_ready = 1'b0;
    spi_tx_tready = 1'b0; spi_rx_tvalid = 1'b0; spi_rx_tdata = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_random();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_seq.md
Name: spi_cmd_seq

Overview:
- Register-access front-end that sits directly upstream of the SPI master.
- Accepts host read/write requests, queues them in a command FIFO, and packs each into the master's 32-bit MSB-first transmit word.
- Drives the master's stream transmit interface one transaction at a time.
- Returns one response per request: read data, or completion/error for writes, with a timeout guard.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 65536, clk cycles allowed from SPI handshake to completion before error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_adr_bits  in  8  address-phase bit count incl. R/W bit (must match master par_adr_sclknum)
- cfg_dat_bits  in  8  data-phase bit count (must match master par_dat_sclknum)
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_rw  in  1  1=read, 0=write
- req_addr  in  24  register address, LSB-aligned
- req_wdata  in  24  write data, LSB-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted when valid&ready
- rsp_rw  out  1  echo of request R/W
- rsp_err  out  1  1=timeout or illegal config
- rsp_rdata  out  24  read data, LSB-aligned; 0 for writes/errors
- spi_tx_tvalid  out  1  to master tx_tvalid
- spi_tx_tdata  out  32  to master tx_tdata
- spi_tx_tready  in  1  from master tx_tready
- spi_rx_tvalid  in  1  from master rx_tvalid
- spi_rx_tdata  in  32  from master rx_tdata
- busy  out  1  FIFO non-empty or FSM not IDLE
- stat_txn_cnt  out  16  completed transactions (optional feature)
- stat_tmo_cnt  out  16  timeouts (optional feature)

Behaviour:
- Reset values: req_ready=0 during reset, 1 on the first cycle after reset; rsp_valid=0, rsp_err=0, rsp_rw=0, rsp_rdata=0, spi_tx_tvalid=0, spi_tx_tdata=0, busy=0; FIFO empty; FSM in IDLE.
- Reset mid-transaction: FIFO flushed, no response issued.
- req_ready = !fifo_full. Packing is done at enqueue, using the cfg values sampled in the enqueue cycle, with A=cfg_adr_bits and D=cfg_dat_bits.
- Packed word fields:
  - tdata[31] = req_rw.
  - The next A-1 bits = req_addr[A-2:0].
  - The next D bits = req_wdata[D-1:0] for writes, zeros for reads.
  - All remaining LSBs = 0.
- Illegal config (A<2, D=0, or A+D>32): entry marked bad; no SPI transaction; response rsp_err=1.
- Each FIFO entry holds: packed word, rw, D, bad flag. Simultaneous push and pop is allowed in the same cycle, including when full (pop frees the slot; req_ready still reflects pre-pop full). Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if FIFO non-empty, pop the head. If bad, go to RESP with err=1. Otherwise go to ISSUE.
  - ISSUE: spi_tx_tvalid=1 and spi_tx_tdata=word, both held stable until spi_tx_tready=1. On handshake, drop tvalid the next cycle, clear the timer, and go to WAIT_LOW.
  - WAIT_LOW: wait for spi_tx_tready=0, which means the master has started. Then go to WAIT_DONE.
  - WAIT_DONE, read: done on spi_rx_tvalid; capture rdata = spi_rx_tdata[D-1:0], upper bits 0.
  - WAIT_DONE, write: done on the first cycle spi_tx_tready=1.
  - RESP: rsp_valid=1 and fields held stable until rsp_ready. Return to IDLE the next cycle.
- Timer runs in WAIT_LOW and WAIT_DONE. When it reaches TIMEOUT_CYCLES, go to RESP with err=1 and rdata=0.
- After a timeout, the next ISSUE still waits on spi_tx_tready. spi_rx_tvalid outside WAIT_DONE is ignored.
- Single outstanding transaction: the next pop happens only after the response is accepted. Minimum request-to-ISSUE latency: 2 cycles (enqueue, then IDLE pop).

Optional Feature:
SPI_SEQ_STATS_EN
- Defined:
  - stat_txn_cnt increments on every response handshake.
  - stat_tmo_cnt increments on every timeout response.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are driven constant 0 and no counter logic is built.

Test Plan:
- A=16, D=8; write addr 0x12, wdata 0xAB -> spi_tx_tdata=0x0012AB00; model tready low 40 cycles then high -> rsp_valid, rsp_err=0, rsp_rw=0, rsp_rdata=0.
- A=8, D=24; read addr 0x05 -> tdata=0x85000000; model returns rx_tdata=0x00C0FFEE -> rsp_rdata=0xC0FFEE, err=0.
- Push FIFO_DEPTH+1 requests with rsp_ready=0 -> req_ready drops after FIFO_DEPTH+1 accepts (one in FSM); release rsp_ready -> all responses returned in order, addresses intact across pointer wrap.
- TIMEOUT_CYCLES=100; model never lowers tready after handshake -> err=1 at 100 cycles, rdata=0; stat_tmo_cnt=1 with SPI_SEQ_STATS_EN.
- A=24, D=16 (sum 40) -> no spi_tx_tvalid, immediate rsp_err=1.
- Assert rst_n mid-WAIT_DONE with 3 queued -> all outputs return to reset values; after release, no response emitted and busy=0.
